// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF-stage next-PC generator and its fetch queue.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_pc;
  } fetch_meta_t;

  // Instruction fetch is word-granular; low address bits are always cleared.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/fetch_pc_gen_if.sv
// BHT lookup, IMEM request/response, MEM redirect and decode handshake of the fetch stage.
interface fetch_pc_gen_if;
  import fetch_pkg::*;

  logic [XLEN-1:0] bht_pc;
  logic            bht_valid;
  logic [XLEN-1:0] bht_pred_pc;

  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;

  logic            redirect;
  logic [XLEN-1:0] redirect_pc;

  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;
  logic            if_pred_taken;
  logic [XLEN-1:0] if_pred_pc;

  modport master (
    output bht_pc, imem_req_valid, imem_req_addr,
    output if_valid, if_pc, if_instr, if_pred_taken, if_pred_pc,
    input  bht_valid, bht_pred_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect, redirect_pc, if_ready
  );

  modport slave (
    input  bht_pc, imem_req_valid, imem_req_addr,
    input  if_valid, if_pc, if_instr, if_pred_taken, if_pred_pc,
    output bht_valid, bht_pred_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect, redirect_pc, if_ready
  );

endinterface

// File: rtl/fetch_pc_gen_queue.sv
// In-order fetch queue: a slot is allocated at issue, filled when IMEM returns, freed at decode.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int FQ_DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  fetch_meta_t                push_meta,
  input  logic                       fill,
  input  logic [XLEN-1:0]            fill_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic                       head_valid,
  output fetch_meta_t                head_meta,
  output logic [XLEN-1:0]            head_instr,
  output logic [$clog2(FQ_DEPTH):0]  filled_cnt
);

  localparam int AW = $clog2(FQ_DEPTH);

  fetch_meta_t         meta_q  [FQ_DEPTH];
  logic [XLEN-1:0]     instr_q [FQ_DEPTH];
  logic [FQ_DEPTH-1:0] dv_q;
  logic [AW:0]         wr_ptr, fill_ptr, rd_ptr;
  logic [AW-1:0]       wr_idx, fill_idx, rd_idx;

  assign wr_idx   = wr_ptr[AW-1:0];
  assign fill_idx = fill_ptr[AW-1:0];
  assign rd_idx   = rd_ptr[AW-1:0];

  assign head_valid = (wr_ptr != rd_ptr) && dv_q[rd_idx];
  assign head_meta  = meta_q[rd_idx];
  assign head_instr = instr_q[rd_idx];
  assign filled_cnt = fill_ptr - rd_ptr;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      fill_ptr <= '0;
      rd_ptr   <= '0;
      dv_q     <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      fill_ptr <= '0;
      rd_ptr   <= '0;
      dv_q     <= '0;
    end else begin
      if (push) begin
        wr_ptr       <= wr_ptr + (AW+1)'(1);
        dv_q[wr_idx] <= 1'b0;
      end
      if (fill) begin
        fill_ptr       <= fill_ptr + (AW+1)'(1);
        dv_q[fill_idx] <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) meta_q[wr_idx]    <= push_meta;
    if (fill) instr_q[fill_idx] <= fill_data;
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// IF-stage next-PC generator: zero-bubble BHT prediction, credit-limited IMEM issue,
// redirect flush with stale-response dropping, and in-order hand-off to decode.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              FQ_DEPTH = 2
) (
  input logic            clock,
  input logic            reset,
  fetch_pc_gen_if.master fif
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;

  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   in_flight_q, drop_cnt_q, filled_cnt, occupancy;
  logic            head_valid, pop, has_credit, req_valid, issue, rsp_fill;
  logic [XLEN-1:0] pred_pc, head_instr;
  fetch_meta_t     push_meta, head_meta;

  // A slot freed by decode this cycle is reusable immediately, sustaining one fetch per cycle.
  assign pop        = head_valid && fif.if_ready;
  assign occupancy  = in_flight_q + filled_cnt - CW'(pop);
  assign has_credit = occupancy < CW'(FQ_DEPTH);
  assign req_valid  = reset && !fif.redirect && has_credit;
  assign issue      = req_valid && fif.imem_req_ready;

  assign pred_pc   = fif.bht_valid ? align_pc(fif.bht_pred_pc) : pc_q + PC_STEP;
  assign push_meta = '{pc: pc_q, pred_taken: fif.bht_valid, pred_pc: pred_pc};

  // Responses to requests issued before a redirect are discarded, including one arriving with it.
  assign rsp_fill = fif.imem_rsp_valid && !fif.redirect && (drop_cnt_q == '0);

  assign fif.bht_pc         = pc_q;
  assign fif.imem_req_addr  = pc_q;
  assign fif.imem_req_valid = req_valid;

  assign fif.if_valid      = head_valid;
  assign fif.if_pc         = head_valid ? head_meta.pc         : '0;
  assign fif.if_instr      = head_valid ? head_instr           : '0;
  assign fif.if_pred_taken = head_valid && head_meta.pred_taken;
  assign fif.if_pred_pc    = head_valid ? head_meta.pred_pc    : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q        <= RESET_PC;
      in_flight_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (fif.redirect)  pc_q <= align_pc(fif.redirect_pc);
      else if (issue)    pc_q <= pred_pc;

      in_flight_q <= in_flight_q + CW'(issue) - CW'(fif.imem_rsp_valid);

      if (fif.redirect)
        drop_cnt_q <= in_flight_q - CW'(fif.imem_rsp_valid);
      else if (fif.imem_rsp_valid && (drop_cnt_q != '0))
        drop_cnt_q <= drop_cnt_q - CW'(1);
    end
  end

  fetch_queue #(.FQ_DEPTH(FQ_DEPTH)) u_queue (
    .clock      (clock),
    .reset      (reset),
    .push       (issue),
    .push_meta  (push_meta),
    .fill       (rsp_fill),
    .fill_data  (fif.imem_rsp_data),
    .pop        (pop),
    .flush      (fif.redirect),
    .head_valid (head_valid),
    .head_meta  (head_meta),
    .head_instr (head_instr),
    .filled_cnt (filled_cnt)
  );

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Randomized scoreboard bench for fetch_pc_gen with a behavioural BHT/IMEM/fetch-stream model.
module tb_fetch_pc_gen;
  import fetch_pkg::*;

  localparam int          FQ_DEPTH = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  fetch_pc_gen_if fif();

  fetch_pc_gen #(.RESET_PC(RESET_PC), .FQ_DEPTH(FQ_DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .fif   (fif)
  );

  // BHT: entries whose word index bits [6:2] equal 4 predict a jump 0x70 ahead; the raw target
  // carries a stray low bit, and misses present garbage that must be ignored.
  function automatic bit bht_hit(input logic [31:0] pc);
    return ((pc >> 2) % 32) == 4;
  endfunction

  assign fif.bht_valid   = bht_hit(fif.bht_pc);
  assign fif.bht_pred_pc = bht_hit(fif.bht_pc) ? fif.bht_pc + 32'h71 : fif.bht_pc ^ 32'hDEAD_BEE3;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return (pc * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] next_pc_of(input logic [31:0] pc);
    return bht_hit(pc) ? pc + 32'h70 : pc + 32'd4;
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        taken;
    logic [31:0] pred;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          acc;
  } req_t;

  exp_t        live_q[$];
  req_t        imem_q[$];
  logic [31:0] exp_pc = RESET_PC;
  int          stale_cnt = 0;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          n_deliv = 0;
  int          n_issue = 0;
  int          ready_pct = 100, rsp_pct = 100, ifr_pct = 100, redir_pm = 0;
  bit          stall_prev = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [31:0] pick_rpc();
    int r;
    r = $urandom_range(3);
    if (r == 0) return 32'hFFFF_FFFC;
    if (r == 1) return 32'h0000_0010;
    return $urandom & 32'h0000_FFFF;
  endfunction

  // Driver: new inputs shortly after each rising edge; IMEM answers in order, >=1 cycle after accept.
  task automatic drive_cycle();
    @(posedge clock);
    #1;
    fif.imem_req_ready = ($urandom_range(99) < ready_pct);
    fif.if_ready       = ($urandom_range(99) < ifr_pct);
    fif.redirect       = 1'b0;
    if ($urandom_range(999) < redir_pm) begin
      fif.redirect    = 1'b1;
      fif.redirect_pc = pick_rpc();
    end
    fif.imem_rsp_valid = 1'b0;
    if (imem_q.size() > 0 && imem_q[0].acc < cyc && $urandom_range(99) < rsp_pct) begin
      fif.imem_rsp_valid = 1'b1;
      fif.imem_rsp_data  = instr_of(imem_q[0].addr);
      void'(imem_q.pop_front());
      if (stale_cnt > 0) stale_cnt--;
    end
  endtask

  task automatic drive_redirect(input logic [31:0] pc);
    drive_cycle();
    fif.redirect    = 1'b1;
    fif.redirect_pc = pc;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_if_valid"},  fif.if_valid, 0);
    chk({tag, "_req_valid"}, fif.imem_req_valid, 0);
    chk({tag, "_bht_pc"},    fif.bht_pc, RESET_PC);
    chk({tag, "_if_pc"},     fif.if_pc, 0);
    chk({tag, "_if_instr"},  fif.if_instr, 0);
    chk({tag, "_if_taken"},  fif.if_pred_taken, 0);
    chk({tag, "_if_pred"},   fif.if_pred_pc, 0);
  endtask

  // Output monitor: whatever decode sees must be the oldest live expected entry.
  always begin
    @(negedge clock);
    if (!reset) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) chk("if_hold_valid", fif.if_valid, 1);
      if (fif.if_valid) begin
        if (live_q.size() == 0) begin
          n_chk++;
          $display("FAIL if_unexpected: got if_pc %08h while no instruction is expected", fif.if_pc);
        end else begin
          chk("if_pc",    fif.if_pc, live_q[0].pc);
          chk("if_instr", fif.if_instr, live_q[0].instr);
          chk("if_taken", fif.if_pred_taken, live_q[0].taken);
          chk("if_pred",  fif.if_pred_pc, live_q[0].pred);
          if (fif.if_ready) begin
            void'(live_q.pop_front());
            n_deliv++;
          end
        end
      end
      stall_prev = fif.if_valid && !fif.if_ready && !fif.redirect;
    end
  end

  // Request monitor: predicts every fetch address and records the expected decode entry.
  always begin
    @(negedge clock);
    #1;
    if (reset) begin
      if (fif.redirect) begin
        chk("req_blocked_on_redirect", fif.imem_req_valid, 0);
        live_q.delete();
        stale_cnt = imem_q.size();
        exp_pc = fif.redirect_pc & ~32'd3;
      end else if (fif.imem_req_valid && fif.imem_req_ready) begin
        chk("req_addr", fif.imem_req_addr, exp_pc);
        chk("req_credit", (live_q.size() + stale_cnt) < FQ_DEPTH, 1);
        live_q.push_back('{pc: exp_pc, instr: instr_of(exp_pc), taken: bht_hit(exp_pc),
                           pred: next_pc_of(exp_pc)});
        imem_q.push_back('{addr: exp_pc, acc: cyc});
        n_issue++;
        exp_pc = next_pc_of(exp_pc);
      end
    end
  end

  initial begin
    int k;
    fif.imem_req_ready = 1'b0;
    fif.imem_rsp_valid = 1'b0;
    fif.imem_rsp_data  = '0;
    fif.redirect       = 1'b0;
    fif.redirect_pc    = '0;
    fif.if_ready       = 1'b0;

    #12;
    check_reset_outputs("reset");
    @(posedge clock);
    #1;
    reset = 1'b1;

    // Straight-line stream with a BHT hit at 0x10.
    n_issue = 0;
    repeat (24) drive_cycle();
    chk("stream_rate", n_issue >= 20, 1);

    // Decode stall: the queue fills, fetching stops, the head is held.
    ifr_pct = 0;
    n_issue = 0;
    repeat (8) drive_cycle();
    chk("stall_no_req", fif.imem_req_valid, 0);
    chk("stall_if_valid", fif.if_valid, 1);
    chk("stall_issue_bound", n_issue <= FQ_DEPTH, 1);
    ifr_pct = 100;
    repeat (10) drive_cycle();

    // Two requests in flight, then redirect: both responses must be dropped.
    rsp_pct = 0;
    repeat (4) drive_cycle();
    drive_redirect(32'h0000_0200);
    rsp_pct = 100;
    drive_cycle();
    chk("redirect_pc", fif.bht_pc, 32'h0000_0200);
    chk("redirect_flush", fif.if_valid, 0);
    repeat (10) drive_cycle();

    // Sequential fetch wraps past the top of the address space.
    drive_redirect(32'hFFFF_FFFC);
    drive_cycle();
    chk("wrap_start", fif.bht_pc, 32'hFFFF_FFFC);
    k = 0;
    while (fif.bht_pc == 32'hFFFF_FFFC && k < 8) begin
      drive_cycle();
      k++;
    end
    chk("wrap_next", fif.bht_pc, 32'h0000_0000);
    repeat (6) drive_cycle();

    // Random traffic with redirects.
    ready_pct = 75; rsp_pct = 60; ifr_pct = 70; redir_pm = 30;
    repeat (1500) drive_cycle();

    // Reset mid-stream, away from the clock edge.
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    fif.imem_rsp_valid = 1'b0;
    fif.redirect       = 1'b0;
    live_q.delete();
    imem_q.delete();
    stale_cnt = 0;
    exp_pc = RESET_PC;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (300) drive_cycle();

    // Drain: no new requests, everything outstanding must reach decode.
    ready_pct = 0; rsp_pct = 100; ifr_pct = 100; redir_pm = 0;
    repeat (12) drive_cycle();
    chk("drain_live", live_q.size(), 0);
    chk("drain_imem", imem_q.size(), 0);
    chk("delivered_count", n_deliv > 200, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
